// File: rtl/spi_tx_arbiter_pkg.sv
// Shared state encoding and width helper for the SPI write-channel arbiter.
package spi_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  // ceil(log2(n)) but never below 1, so single-bit fields stay legal
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_priority_pick.sv
// Round-robin pick: rotate requests so ptr lands at bit 0, find first one, rotate back.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_any,
  output logic [ID_W-1:0]    o_idx
);

  logic [NUM_REQ-1:0] w_rot;
  logic [ID_W-1:0]    w_off;

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_rot[k] = i_req[ID_W'((int'(i_ptr) + k) % NUM_REQ)];
    end
  end

  // Scanning downwards leaves the lowest set offset as the winner
  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_W'(k);
    end
  end

  assign o_any = |i_req;
  assign o_idx = ID_W'((int'(i_ptr) + int'(w_off)) % NUM_REQ);

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI_MASTER write channel (WR/DATA/BUSY) among requesters.
module spi_tx_arbiter
  import spi_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  DATA_W       = 64,
  parameter int  BUSY_TIMEOUT = 16,
  localparam int ID_W         = clog2_min1(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data_in,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_timeout,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_m_wr,
  output logic [DATA_W-1:0]         o_m_data,
  input  logic                      i_m_busy
);

  localparam int CNT_W = clog2_min1(BUSY_TIMEOUT);

  arb_state_t          r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]     r_grant, w_grant_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic                r_wr, w_wr_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;

  logic                w_any;
  logic [ID_W-1:0]     w_pick;
  logic [ID_W-1:0]     w_ptr_after;
  logic [DATA_W-1:0]   w_lane [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign w_lane[i] = i_data_in[i*DATA_W +: DATA_W];
  end

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_pick)
  );

  assign w_ptr_after = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

  // Registered outputs are computed one cycle early so WR/ACK appear in ISSUE itself
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_ack_nxt     = '0;
    w_done_nxt    = '0;
    w_timeout_nxt = 1'b0;
    w_wr_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_m_busy && w_any) begin
          w_grant_nxt = w_pick;
          w_data_nxt  = w_lane[w_pick];
          w_wr_nxt    = 1'b1;
          w_ack_nxt   = NUM_REQ'(1) << w_pick;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i_m_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          w_timeout_nxt = 1'b1;
          w_ptr_nxt     = w_ptr_after;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_m_busy) begin
          w_done_nxt  = NUM_REQ'(1) << r_grant;
          w_ptr_nxt   = w_ptr_after;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_timeout <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_ack     <= w_ack_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_wr      <= w_wr_nxt;
    end
  end

  assign o_ack      = r_ack;
  assign o_done     = r_done;
  assign o_timeout  = r_timeout;
  assign o_grant_id = r_grant;
  assign o_m_wr     = r_wr;
  assign o_m_data   = r_data;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboarded bench: requester queues and a BUSY-responder model feed expectations to a monitor.
module tb_spi_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [DW-1:0]  laneData [NR];
  logic [NR*DW-1:0] dataIn;
  logic [NR-1:0]  ack, done;
  logic           timeoutPulse, mWr, mBusy = 1'b0;
  logic [1:0]     grantId;
  logic [DW-1:0]  mData;

  assign dataIn = {laneData[3], laneData[2], laneData[1], laneData[0]};

  spi_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_data_in  (dataIn),
    .o_ack      (ack),
    .o_done     (done),
    .o_timeout  (timeoutPulse),
    .o_grant_id (grantId),
    .o_m_wr     (mWr),
    .o_m_data   (mData),
    .i_m_busy   (mBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit isTimeout;
    int id;
    int due;
  } exp_t;

  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [DW-1:0] wordQ [NR][$];
  exp_t        expQ [$];
  int          grantLog [$];
  int          modelPtr = 0;
  int          holdPct = 0, toPct = 0, fixedD = 0, fixedL = 0;
  bit          forceTimeout = 0, slaveHold = 0, slaveBusy = 0;
  int          planD = 1, planL = 1;
  bit          planTo = 0, planHold = 0;
  logic [NR-1:0] reqPrev = '0;
  logic [DW-1:0] dataPrev [NR];
  logic        busyPrev = 1'b0, rstPrev = 1'b1;
  logic [DW-1:0] lastMdata = '0;
  int          lastGrant = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  // A one-shot forced timeout is consumed by the next plan drawn
  function automatic void drawPlan();
    planD = (fixedD > 0) ? fixedD : $urandom_range(1, 3);
    planL = (fixedL > 0) ? fixedL : $urandom_range(1, 6);
    planTo = forceTimeout || ($urandom_range(0, 99) < toPct);
    planHold = slaveHold;
    forceTimeout = 0;
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) laneData[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (wordQ[i].size() > 0) begin
          laneData[i] = wordQ[i][0];
          req[i] = ($urandom_range(0, 99) >= holdPct);
        end else begin
          laneData[i] = {$urandom, $urandom};
          req[i] = 1'b0;
        end
      end
    end
  end

  // Stand-in for SPI_MASTER: answers each WR according to the plan drawn beforehand
  initial begin
    forever begin
      @(negedge clk);
      if (mWr) begin
        int pd, pl;
        bit pto, ph;
        slaveBusy = 1;
        pd = planD; pl = planL; pto = planTo; ph = planHold;
        @(posedge clk);
        drawPlan();
        if (!pto) begin
          repeat (pd - 1) @(posedge clk);
          #1 mBusy = 1'b1;
          if (ph) begin
            while (slaveHold) @(posedge clk);
          end else begin
            repeat (pl) @(posedge clk);
          end
          #1 mBusy = 1'b0;
        end
        slaveBusy = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) dataPrev[i] = '0;
    forever begin
      @(negedge clk);
      if (rstPrev) begin
        checkOutput("resetOutputs", {51'd0, ack, done, timeoutPulse, mWr, grantId, |mData}, 64'd0);
        expQ.delete();
        modelPtr = 0;
        lastMdata = '0;
        lastGrant = 0;
      end else begin
        checkOutput("ackDoneExclusive", {63'd0, $onehot0(ack) && $onehot0(done) && !(|ack && |done)}, 64'd1);
        checkOutput("wrWithAck", {63'd0, mWr}, {63'd0, |ack});
        if (|ack) begin
          int g;
          g = -1;
          for (int k = 0; k < NR; k++)
            if (g < 0 && reqPrev[(modelPtr + k) % NR]) g = (modelPtr + k) % NR;
          checkOutput("noGrantWhileBusy", {63'd0, busyPrev}, 64'd0);
          if (g < 0) begin
            checkOutput("spuriousAck", {60'd0, ack}, 64'd0);
          end else begin
            checkOutput("ackIndex", {60'd0, ack}, 64'd1 << g);
            checkOutput("grantId", {62'd0, grantId}, g);
            checkOutput("latchedData", mData, dataPrev[g]);
            expQ.push_back('{planTo, g, planTo ? cyc + TO + 1 : (planHold ? -1 : cyc + planD + planL + 1)});
            grantLog.push_back(g);
            modelPtr = (g + 1) % NR;
            if (wordQ[g].size() > 0) void'(wordQ[g].pop_front());
            lastMdata = dataPrev[g];
            lastGrant = g;
          end
        end else begin
          checkOutput("dataHeld", mData, lastMdata);
          checkOutput("grantHeld", {62'd0, grantId}, lastGrant);
        end
        if (|done || timeoutPulse) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedCompletion", {59'd0, timeoutPulse, done}, 64'd0);
          end else begin
            exp_t e;
            logic [4:0] wantK;
            e = expQ.pop_front();
            wantK = e.isTimeout ? 5'b10000 : (5'b00001 << e.id);
            checkOutput("completionKind", {59'd0, timeoutPulse, done}, {59'd0, wantK});
            if (e.due >= 0) checkOutput("completionCycle", cyc, e.due);
          end
        end
      end
      rstPrev = rst;
      reqPrev = req;
      busyPrev = mBusy;
      for (int i = 0; i < NR; i++) dataPrev[i] = laneData[i];
    end
  end

  function automatic bit pending();
    bit p;
    p = (expQ.size() != 0) || mBusy || slaveBusy;
    for (int i = 0; i < NR; i++) if (wordQ[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, {63'd0, n < budget}, 64'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic checkLog(input string name, input int e0, input int e1, input int e2,
                          input int e3, input int e4, input int len);
    int want [5];
    want = '{e0, e1, e2, e3, e4};
    checkOutput({name, "Len"}, grantLog.size(), len);
    for (int i = 0; i < len && i < grantLog.size(); i++)
      checkOutput(name, grantLog[i], want[i]);
    grantLog.delete();
  endtask

  task automatic applyStimulus();
    int n;
    @(posedge clk);
    #1;
    applyReset();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] single requester");
    fixedD = 2; fixedL = 10; drawPlan();
    wordQ[2].push_back(64'hA5A5_0000_0000_0001);
    waitDrain("drainSingle", 200);
    checkLog("singleOrder", 2, 0, 0, 0, 0, 1);

    $display("[TB] contention");
    applyReset();
    fixedD = 1; fixedL = 5; drawPlan();
    wordQ[0].push_back(64'h10); wordQ[0].push_back(64'h11);
    wordQ[1].push_back(64'h20); wordQ[2].push_back(64'h30); wordQ[3].push_back(64'h40);
    waitDrain("drainContention", 400);
    checkLog("contentionOrder", 0, 1, 2, 3, 0, 5);

    $display("[TB] wrap and skip");
    wordQ[2].push_back(64'h5555);
    waitDrain("drainWrapPrep", 200);
    grantLog.delete();
    wordQ[0].push_back(64'h6000); wordQ[2].push_back(64'h6002);
    waitDrain("drainWrap", 200);
    checkLog("wrapOrder", 0, 2, 0, 0, 0, 2);

    $display("[TB] busy timeout");
    fixedD = 0; fixedL = 0; forceTimeout = 1; drawPlan();
    wordQ[1].push_back(64'h7001); wordQ[3].push_back(64'h7003);
    waitDrain("drainTimeout", 300);
    checkLog("timeoutOrder", 3, 1, 0, 0, 0, 2);

    $display("[TB] reset mid-transfer");
    slaveHold = 1; fixedD = 1; drawPlan();
    wordQ[1].push_back(64'h8001);
    n = 0;
    while (!mBusy && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkOutput("busyRoseBeforeReset", {63'd0, mBusy}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    wordQ[3].push_back(64'h8003);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    slaveHold = 0; drawPlan();
    waitDrain("drainAfterReset", 200);
    checkLog("resetOrder", 1, 3, 0, 0, 0, 2);

    $display("[TB] randomized traffic");
    fixedD = 0; fixedL = 0; toPct = 8; holdPct = 25; drawPlan();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 100; k++)
        wordQ[i].push_back({8'(i), 24'h0, 32'(k)});
    waitDrain("drainRandom", 30000);
    checkOutput("finalExpQueue", expQ.size(), 64'd0);
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #900000;
    fails++;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
